// File: rtl/led_pwm_ctrl.sv
// LED PWM controller: register file, prescaled PWM counter and per-channel mode mux.
// Optional blink logic is built when LED_PWM_BLINK_EN is defined; led is registered (1 clk).
module led_pwm_ctrl #(
  parameter int NUM_LED            = 4,
  parameter int PWM_BITS           = 8,
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 6
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          wr_en,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] wr_addr,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] wr_data,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] rd_addr,
  output logic [C_S_AXI_DATA_WIDTH-1:0] rd_data,
  output logic [NUM_LED-1:0]            led
);

  localparam logic [PWM_BITS-1:0] PWM_MAX = '1;

  logic                en;
  logic [15:0]         prescale;
  logic [15:0]         pre_cnt;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [1:0]          mode [NUM_LED];
  logic [PWM_BITS-1:0] duty [NUM_LED];
  logic                blink_phase;
  logic [15:0]         blink_rd;

  logic [3:0]          wr_idx;
  logic [3:0]          rd_idx;
  logic                wr_ctrl;
  logic                wr_pre;
  logic                clr;
  logic                tick;
  logic                wrap;
  logic [NUM_LED-1:0]  pwm;
  logic [NUM_LED-1:0]  led_nxt;
  logic                unused_bits;

  assign wr_idx  = wr_addr[5:2];
  assign rd_idx  = rd_addr[5:2];
  assign wr_ctrl = wr_en && (wr_idx == 4'd0);
  assign wr_pre  = wr_en && (wr_idx == 4'd1);
  assign clr     = wr_ctrl && wr_data[1];
  assign tick    = en && (pre_cnt == prescale);
  assign wrap    = tick && (pwm_cnt == PWM_MAX);

  // Address low bits and upper data bits carry no information here.
  assign unused_bits = ^{wr_addr, rd_addr, wr_data};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      en       <= 1'b0;
      prescale <= '0;
    end else begin
      if (wr_ctrl) en       <= wr_data[0];
      if (wr_pre)  prescale <= wr_data[15:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_LED; i++) begin
        mode[i] <= '0;
        duty[i] <= '0;
      end
    end else if (wr_en) begin
      for (int i = 0; i < NUM_LED; i++) begin
        if (wr_idx == 4'(4 + i)) begin
          mode[i] <= wr_data[1:0];
          duty[i] <= wr_data[8 +: PWM_BITS];
        end
      end
    end
  end

  // CLR and a PRESCALE write in the same cycle both land on zero, so one clear suffices.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre_cnt <= '0;
      pwm_cnt <= '0;
    end else if (!en || clr) begin
      pre_cnt <= '0;
      pwm_cnt <= '0;
    end else begin
      if (wr_pre || tick) pre_cnt <= '0;
      else                pre_cnt <= pre_cnt + 16'd1;
      if (tick)           pwm_cnt <= pwm_cnt + 1'b1;
    end
  end

`ifdef LED_PWM_BLINK_EN
  logic [15:0] blink_half;
  logic [15:0] blink_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blink_half <= '0;
    end else if (wr_en && (wr_idx == 4'd2)) begin
      blink_half <= wr_data[15:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (!en || clr) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (wrap) begin
      if (blink_cnt == blink_half) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + 16'd1;
      end
    end
  end

  assign blink_rd = blink_half;
`else
  // Without blink support mode 3 collapses onto plain PWM.
  assign blink_phase = 1'b1;
  assign blink_rd    = '0;
`endif

  always_comb begin
    pwm = '0;
    for (int i = 0; i < NUM_LED; i++) pwm[i] = (pwm_cnt < duty[i]);
  end

  always_comb begin
    led_nxt = '0;
    for (int i = 0; i < NUM_LED; i++) begin
      case (mode[i])
        2'd1:    led_nxt[i] = 1'b1;
        2'd2:    led_nxt[i] = pwm[i];
        2'd3:    led_nxt[i] = pwm[i] & blink_phase;
        default: led_nxt[i] = 1'b0;
      endcase
    end
    if (!en) led_nxt = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) led <= '0;
    else       led <= led_nxt;
  end

  always_comb begin
    rd_data = '0;
    case (rd_idx)
      4'd0:    rd_data[0]         = en;
      4'd1:    rd_data[15:0]      = prescale;
      4'd2:    rd_data[15:0]      = blink_rd;
      4'd3:    rd_data[NUM_LED-1:0] = led;
      default: begin
        for (int i = 0; i < NUM_LED; i++) begin
          if (rd_idx == 4'(4 + i)) begin
            rd_data[1:0]           = mode[i];
            rd_data[8 +: PWM_BITS] = duty[i];
          end
        end
      end
    endcase
  end

endmodule

// File: tb/tb_led_pwm_ctrl.sv
// Directed bench for led_pwm_ctrl: register access, PWM duty counts, CLR, EN, blink, reset.
module tb_led_pwm_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [5:0]  wr_addr;
  logic [31:0] wr_data;
  logic [5:0]  rd_addr;
  logic [31:0] rd_data;
  logic [3:0]  led;

  int compared   = 0;
  int mismatched = 0;
  int hi [4];
  int first_low0;
  logic [31:0] rv;

`ifdef LED_PWM_BLINK_EN
  localparam int          BLINK_HI = 2040;
  localparam logic [31:0] BLINK_RD = 32'd1;
  localparam logic [31:0] LED2_AT100 = 32'd0;
`else
  localparam int          BLINK_HI = 4080;
  localparam logic [31:0] BLINK_RD = 32'd0;
  localparam logic [31:0] LED2_AT100 = 32'd1;
`endif

  led_pwm_ctrl dut (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .led     (led)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [5:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic chk_rd(input string tag, input logic [5:0] a, input logic [31:0] exp);
    rd_addr = a;
    #1;
    chk(tag, rd_data, exp);
  endtask

  // Sample led once per cycle for n cycles; per-bit high counts and first low of led[0].
  task automatic run_count(input int n);
    for (int k = 0; k < 4; k++) hi[k] = 0;
    first_low0 = -1;
    for (int j = 0; j < n; j++) begin
      step();
      for (int k = 0; k < 4; k++) if (led[k]) hi[k]++;
      if (!led[0] && first_low0 < 0) first_low0 = j;
    end
  endtask

  initial begin
    reset = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0;
    #1 reset = 1'b1;
    #10;
    chk("reset_led", {28'd0, led}, 32'd0);
    chk_rd("reset_ctrl", 6'h00, 32'd0);
    chk_rd("reset_prescale", 6'h04, 32'd0);
    chk_rd("reset_blink", 6'h08, 32'd0);
    chk_rd("reset_status", 6'h0C, 32'd0);
    chk_rd("reset_ch0", 6'h10, 32'd0);
    #2 reset = 1'b0;
    step();

    // PWM duty 64 / 0 / 255 with PRESCALE=0
    wr(6'h10, 32'h0000_4002);
    wr(6'h14, 32'h0000_0002);
    wr(6'h1C, 32'h0000_FF02);
    chk_rd("ch0_readback", 6'h10, 32'h0000_4002);
    chk_rd("ch3_readback", 6'h1C, 32'h0000_FF02);
    wr(6'h00, 32'h1);
    chk_rd("ctrl_en", 6'h00, 32'h1);
    run_count(256);
    chk("ch0_high_count", hi[0], 32'd64);
    chk("ch0_first_low", first_low0, 32'd64);
    chk("ch1_duty0_count", hi[1], 32'd0);
    chk("ch3_duty255_count", hi[3], 32'd255);

    // CLR mid-period: PWM counter restarts, so led[0] is high for the next 64 cycles
    run_count(100);
    chk("pre_clr_led0_low", {31'd0, led[0]}, 32'd0);
    wr(6'h00, 32'h3);
    chk_rd("ctrl_clr_selfclear", 6'h00, 32'h1);
    run_count(65);
    chk("post_clr_high", hi[0], 32'd64);
    chk("post_clr_first_low", first_low0, 32'd64);

    // EN=0 forces led low one cycle later
    wr(6'h00, 32'h0);
    step();
    chk("en0_led", {28'd0, led}, 32'd0);
    wr(6'h14, 32'h0000_0001);
    run_count(5);
    chk("en0_on_mode_masked", hi[1], 32'd0);

    // Writes to STATUS, unmapped and nonexistent channel are ignored
    wr(6'h0C, 32'hFFFF_FFFF);
    wr(6'h3C, 32'hFFFF_FFFF);
    wr(6'h24, 32'h0000_FF03);
    chk_rd("status_ro", 6'h0C, 32'd0);
    chk_rd("unmapped_3c", 6'h3C, 32'd0);
    chk_rd("ch5_absent", 6'h24, 32'd0);
    chk_rd("ctrl_untouched", 6'h00, 32'd0);
    chk_rd("prescale_untouched", 6'h04, 32'd0);
    chk_rd("ch0_untouched", 6'h10, 32'h0000_4002);

    // Blink: PRESCALE=3 (1024-clk PWM period), BLINK_HALF=1, CH2 mode 3 duty 255
    wr(6'h04, 32'd3);
    wr(6'h08, 32'd1);
    wr(6'h18, 32'h0000_FF03);
    wr(6'h10, 32'h0);
    wr(6'h1C, 32'h0);
    chk_rd("prescale_rd", 6'h04, 32'd3);
    chk_rd("blink_half_rd", 6'h08, BLINK_RD);
    wr(6'h00, 32'h1);
    run_count(101);
    chk("blink_led2_early", {31'd0, led[2]}, LED2_AT100);
    run_count(3995);
    chk("blink_led2_count", hi[2] + ((LED2_AT100 != 0) ? 101 : 0), BLINK_HI);
    chk("blink_led1_on", hi[1], 32'd3995);
    chk("blink_led0_off", hi[0], 32'd0);

    // Reset pulse mid-blink clears everything without waiting for a clock edge
    run_count(2100);
    chk("pre_reset_led", {28'd0, led}, 32'h6);
    #2 reset = 1'b1;
    #1;
    chk("async_reset_led", {28'd0, led}, 32'd0);
    chk_rd("async_reset_ctrl", 6'h00, 32'd0);
    chk_rd("async_reset_prescale", 6'h04, 32'd0);
    chk_rd("async_reset_ch2", 6'h18, 32'd0);
    #20 reset = 1'b0;
    run_count(10);
    chk("post_reset_led_idle", hi[1] + hi[2], 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
